spike_fanout_scheduler: RTL and testbench

Drains the per-timestep spike FIFO filled by the neuron update sweep and expands each spiking neuron into its synaptic fan-out events. Each popped source address indexes a fan-out pointer table holding {base, count}. The block then streams count consecutive synapse addresses to the downstream synaptic accumulator over a valid/ready handshake. It sits between the spike output FIFO and the synapse-event datapath, and signals phase completion so the top-level sequencer can start the next timestep sweep.

---
 rtl/spike_fanout_scheduler.sv | 129 ++++++++++++
 tb/tb_spike_fanout_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_fanout_scheduler.sv
// Spike fan-out scheduler: pops source neurons from the spike FIFO and
// streams each source's consecutive synapse addresses downstream.
module spike_fanout_scheduler #(
  parameter int ADDR_WIDTH = 14,
  parameter int PTR_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic                          i_fifo_empty,
  input  logic [ADDR_WIDTH-1:0]         i_fifo_rd_data,
  output logic                          o_fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_ptr_rd_addr,
  input  logic [PTR_WIDTH+CNT_WIDTH-1:0] i_ptr_rd_data,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [PTR_WIDTH-1:0]          o_evt_syn_addr,
  output logic [ADDR_WIDTH-1:0]         o_evt_src,
  output logic                          o_evt_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [15:0]                   o_evt_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_RD,
    S_PTR_WAIT,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] last_idx;
  logic [PTR_WIDTH-1:0] ld_base;
  logic [CNT_WIDTH-1:0] ld_cnt;
  logic                 fire;
  logic                 is_last;

  assign ld_base = i_ptr_rd_data[PTR_WIDTH+CNT_WIDTH-1 -: PTR_WIDTH];
  assign ld_cnt  = i_ptr_rd_data[CNT_WIDTH-1:0];
  assign is_last = (idx == last_idx);
  assign fire    = o_evt_valid & i_evt_ready;

  always_comb begin
    state_nxt    = state;
    o_fifo_rd_en = 1'b0;
    o_evt_valid  = 1'b0;
    o_evt_last   = 1'b0;
    o_busy       = (state != S_IDLE);
    o_done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_POP;
      end
      S_POP: begin
        if (i_fifo_empty) begin
          state_nxt = S_DONE;
        end else begin
          o_fifo_rd_en = 1'b1;
          state_nxt    = S_RD;
        end
      end
      S_RD:       state_nxt = S_PTR_WAIT;
      S_PTR_WAIT: state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt = (ld_cnt == '0) ? S_POP : S_EMIT;
      end
      S_EMIT: begin
        o_evt_valid = 1'b1;
        o_evt_last  = is_last;
        if (i_evt_ready && is_last) state_nxt = S_POP;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ptr_rd_addr  <= '0;
      o_evt_src      <= '0;
      o_evt_syn_addr <= '0;
      idx            <= '0;
      last_idx       <= '0;
    end else begin
      if (state == S_RD) begin
        o_ptr_rd_addr <= i_fifo_rd_data;
        o_evt_src     <= i_fifo_rd_data;
      end
      if (state == S_LOAD) begin
        o_evt_syn_addr <= ld_base;
        idx            <= '0;
        last_idx       <= ld_cnt - 1'b1;
      end else if (fire && !is_last) begin
        // address wraps modulo 2^PTR_WIDTH by construction
        o_evt_syn_addr <= o_evt_syn_addr + 1'b1;
        idx            <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_evt_count <= '0;
    end else if (state == S_IDLE && i_start) begin
      o_evt_count <= '0;
    end else if (fire && o_evt_count != 16'hFFFF) begin
      o_evt_count <= o_evt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_spike_fanout_scheduler.sv
// Scoreboard bench for spike_fanout_scheduler: directed FIFO/table
// scenarios, expected events queued, monitor pops on each handshake.
module tb_spike_fanout_scheduler;

  localparam int AW = 14;
  localparam int PW = 16;
  localparam int CW = 8;

  typedef struct packed {
    logic [PW-1:0] syn;
    logic [AW-1:0] src;
    logic          last;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_fifo_empty;
  logic [AW-1:0] i_fifo_rd_data = '0;
  logic          o_fifo_rd_en;
  logic [AW-1:0] o_ptr_rd_addr;
  logic [PW+CW-1:0] i_ptr_rd_data = '0;
  logic          o_evt_valid;
  logic          i_evt_ready = 1'b1;
  logic [PW-1:0] o_evt_syn_addr;
  logic [AW-1:0] o_evt_src;
  logic          o_evt_last;
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_evt_count;

  int checks = 0;
  int errors = 0;

  evt_t          sb[$];
  logic [AW-1:0] fifo_q[$];
  logic [PW+CW-1:0] tbl [0:31];

  int  ncyc = 0;
  int  done_cnt = 0;
  int  done_at = 0;
  int  acc_cnt = 0;
  int  first_acc = 0;
  int  last_acc = 0;
  int  first_vld = 0;
  bit  stall_mode = 1'b0;
  int  stall_k = 0;
  bit  held = 1'b0;
  evt_t held_v;

  always #5 clk = ~clk;

  spike_fanout_scheduler #(
    .ADDR_WIDTH(AW), .PTR_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_rd_data(i_fifo_rd_data),
    .o_fifo_rd_en(o_fifo_rd_en),
    .o_ptr_rd_addr(o_ptr_rd_addr),
    .i_ptr_rd_data(i_ptr_rd_data),
    .o_evt_valid(o_evt_valid),
    .i_evt_ready(i_evt_ready),
    .o_evt_syn_addr(o_evt_syn_addr),
    .o_evt_src(o_evt_src),
    .o_evt_last(o_evt_last),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_evt_count(o_evt_count)
  );

  assign i_fifo_empty = (fifo_q.size() == 0);

  // FIFO and pointer table models, both 1-cycle synchronous read
  always @(posedge clk) begin
    if (o_fifo_rd_en && fifo_q.size() > 0)
      i_fifo_rd_data <= fifo_q.pop_front();
    i_ptr_rd_data <= tbl[o_ptr_rd_addr[4:0]];
  end

  // ready pattern 1,0,0,1 repeating while stalling
  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      i_evt_ready = (stall_k % 4 == 0) || (stall_k % 4 == 3);
      stall_k++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: scoreboard pop on handshake, stability and invariants
  always @(negedge clk) begin
    evt_t cur;
    evt_t exp;
    ncyc++;
    cur = '{syn: o_evt_syn_addr, src: o_evt_src, last: o_evt_last};
    if (o_fifo_rd_en && i_fifo_empty) begin
      errors++;
      $display("FAIL rd_en_while_empty: got 1 expected 0");
    end
    if (o_done) begin
      done_cnt++;
      done_at = ncyc;
    end
    if (held) begin
      chk("stall_hold_valid", {31'd0, o_evt_valid}, 32'd1);
      chk("stall_hold_evt", 32'(cur), 32'(held_v));
    end
    held = o_evt_valid && !i_evt_ready && rst_n;
    held_v = cur;
    if (o_evt_valid && first_vld == 0) first_vld = ncyc;
    if (o_evt_valid && i_evt_ready && rst_n) begin
      acc_cnt++;
      if (acc_cnt == 1) first_acc = ncyc;
      last_acc = ncyc;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_evt: got %0h expected none",
                 32'(cur));
      end else begin
        exp = sb.pop_front();
        chk("evt", 32'(cur), 32'(exp));
      end
    end
  end

  task automatic push_src(logic [AW-1:0] src);
    logic [PW-1:0] b;
    logic [CW-1:0] c;
    fifo_q.push_back(src);
    b = tbl[src[4:0]][PW+CW-1 -: PW];
    c = tbl[src[4:0]][CW-1:0];
    for (int i = 0; i < int'(c); i++)
      sb.push_back('{syn: PW'(b + PW'(i)), src: src,
                     last: (i == int'(c) - 1)});
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    s = ncyc;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (done_at <= ncyc - 1 && !o_done && n < 400) begin
      @(negedge clk);
      n++;
      if (o_done) break;
    end
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    @(negedge clk);
  endtask

  task automatic clear_stats();
    acc_cnt = 0;
    first_vld = 0;
    done_at = 0;
  endtask

  initial begin
    int s;
    int d0;
    for (int i = 0; i < 32; i++) tbl[i] = '0;
    tbl[7] = {16'h0100, 8'd3};
    tbl[2] = {16'h1234, 8'd0};
    tbl[5] = {16'hFFFE, 8'd4};

    #12;
    chk("rst_rd_en", {31'd0, o_fifo_rd_en}, 0);
    chk("rst_ptr_addr", 32'(o_ptr_rd_addr), 0);
    chk("rst_valid", {31'd0, o_evt_valid}, 0);
    chk("rst_syn", 32'(o_evt_syn_addr), 0);
    chk("rst_src", 32'(o_evt_src), 0);
    chk("rst_last", {31'd0, o_evt_last}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_count", 32'(o_evt_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // empty FIFO
    clear_stats();
    d0 = done_cnt;
    pulse_start(s);
    wait_done("empty");
    chk("empty_done_lat", 32'(done_at - s), 2);
    chk("empty_busy_after", {31'd0, o_busy}, 0);
    chk("empty_events", 32'(acc_cnt), 0);
    chk("empty_count", 32'(o_evt_count), 0);
    chk("empty_done_once", 32'(done_cnt - d0), 1);

    // single source, 3 events, full throughput
    clear_stats();
    push_src(14'd7);
    pulse_start(s);
    wait_done("one_src");
    chk("one_first_valid", 32'(first_vld - s), 5);
    chk("one_back_to_back", 32'(last_acc - first_acc), 2);
    chk("one_count", 32'(o_evt_count), 3);
    chk("one_sb_empty", 32'(sb.size()), 0);

    // zero-count source then wrapping source
    clear_stats();
    push_src(14'd2);
    push_src(14'd5);
    pulse_start(s);
    wait_done("wrap");
    chk("wrap_count", 32'(o_evt_count), 4);
    chk("wrap_sb_empty", 32'(sb.size()), 0);

    // backpressure
    clear_stats();
    push_src(14'd7);
    stall_k = 0;
    stall_mode = 1'b1;
    pulse_start(s);
    wait_done("stall");
    stall_mode = 1'b0;
    #2 i_evt_ready = 1'b1;
    chk("stall_count", 32'(o_evt_count), 3);
    chk("stall_sb_empty", 32'(sb.size()), 0);

    // reset during second of three events
    clear_stats();
    push_src(14'd7);
    pulse_start(s);
    for (int n = 0; n < 50 && acc_cnt < 1; n++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rst_mid_in_emit", {31'd0, o_evt_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_valid", {31'd0, o_evt_valid}, 0);
    chk("rstm_busy", {31'd0, o_busy}, 0);
    chk("rstm_syn", 32'(o_evt_syn_addr), 0);
    chk("rstm_src", 32'(o_evt_src), 0);
    chk("rstm_count", 32'(o_evt_count), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    d0 = done_cnt;
    pulse_start(s);
    wait_done("post_rst");
    chk("post_rst_done_lat", 32'(done_at - s), 2);
    chk("post_rst_done_once", 32'(done_cnt - d0), 1);

    // start pulsed mid-EMIT is ignored
    clear_stats();
    d0 = done_cnt;
    push_src(14'd7);
    pulse_start(s);
    for (int n = 0; n < 50 && !o_evt_valid; n++) @(negedge clk);
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done("ign_start");
    repeat (6) @(negedge clk);
    chk("ign_count", 32'(o_evt_count), 3);
    chk("ign_done_once", 32'(done_cnt - d0), 1);
    chk("ign_busy", {31'd0, o_busy}, 0);
    chk("ign_sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
